// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by both the receive and transmit paths.
package i2s_pkg;

    localparam int DEFAULT_DW = 24;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } i2s_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, plus a one-cycle
// delayed copy of the synchronised value for edge detection.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync_o,
    output logic dly_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              dly_q;
    logic              dly_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        dly_d  = sync_q[STAGES-1];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign dly_o  = dly_q;

endmodule

// File: rtl/i2s_rx.sv
// Stereo I2S receiver: oversamples bclk/lrclk/sdin on clk, deserialises
// MSB-first words and presents a left/right pair with a one-cycle ena strobe.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DW          = DEFAULT_DW,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bclk,
    input  logic                 lrclk,
    input  logic                 sdin,
    output logic signed [DW-1:0] l_data,
    output logic signed [DW-1:0] r_data,
    output logic                 ena,
    output logic                 frame_err
);

    localparam int CW = $clog2(DW);

    logic bclk_s, bclk_dly;
    logic lr_s, lr_dly;
    logic sdin_s, sdin_dly_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk(clk), .reset(reset), .din(bclk), .sync_o(bclk_s), .dly_o(bclk_dly)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk(clk), .reset(reset), .din(lrclk), .sync_o(lr_s), .dly_o(lr_dly)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdin (
        .clk(clk), .reset(reset), .din(sdin), .sync_o(sdin_s), .dly_o(sdin_dly_unused)
    );

    i2s_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] shift_q, shift_d;
    logic          ch_q, ch_d;
    logic          lr_chg_q, lr_chg_d;
    logic          done_q, done_d;
    logic          done_ch_q, done_ch_d;
    logic          done_short_q, done_short_d;
    logic [DW-1:0] l_hold_q, l_hold_d;
    logic          have_left_q, have_left_d;
    logic [DW-1:0] l_data_q, l_data_d;
    logic [DW-1:0] r_data_q, r_data_d;
    logic          ena_q, ena_d;
    logic          frame_err_q, frame_err_d;

    logic          bclk_rise;
    logic          lr_edge;
    logic          boundary;
    logic [DW-1:0] word;
    logic [CW-1:0] fill;

    // An lrclk change is remembered until the next bclk rise, which is where it counts.
    assign bclk_rise = bclk_s & ~bclk_dly;
    assign lr_edge   = lr_s ^ lr_dly;
    assign boundary  = bclk_rise & (lr_chg_q | lr_edge);
    assign word      = {shift_q[DW-2:0], sdin_s};
    assign fill      = CW'(DW - 1) - cnt_q;

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        ch_d         = ch_q;
        done_d       = 1'b0;
        done_ch_d    = done_ch_q;
        done_short_d = 1'b0;
        lr_chg_d     = bclk_rise ? 1'b0 : (lr_chg_q | lr_edge);

        unique case (state_q)
            SYNC: begin
                if (boundary && lr_s == LEFT) begin
                    state_d = DELAY;
                    ch_d    = LEFT;
                    cnt_d   = '0;
                end
            end
            DELAY: begin
                if (bclk_rise) begin
                    shift_d = {{(DW-1){1'b0}}, sdin_s};
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bclk_rise) begin
                    shift_d = word;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(DW - 1)) begin
                        done_d    = 1'b1;
                        done_ch_d = ch_q;
                        state_d   = boundary ? DELAY : HOLD;
                    end else if (boundary) begin
                        // Short word: the bit at the boundary is its LSB; left-justify.
                        shift_d      = word << fill;
                        done_d       = 1'b1;
                        done_short_d = 1'b1;
                        done_ch_d    = ch_q;
                        state_d      = DELAY;
                    end
                    if (boundary) begin
                        ch_d  = lr_s;
                        cnt_d = '0;
                    end
                end
            end
            HOLD: begin
                if (boundary) begin
                    state_d = DELAY;
                    ch_d    = lr_s;
                    cnt_d   = '0;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // Commit stage: shift_q stays stable for several clk cycles after done_q.
    always_comb begin
        l_hold_d    = l_hold_q;
        have_left_d = have_left_q;
        l_data_d    = l_data_q;
        r_data_d    = r_data_q;
        ena_d       = 1'b0;
        frame_err_d = 1'b0;

        if (done_q) begin
            if (done_ch_q == LEFT) begin
                l_hold_d    = shift_q;
                have_left_d = 1'b1;
                frame_err_d = done_short_q;
            end else if (have_left_q) begin
                l_data_d    = l_hold_q;
                r_data_d    = shift_q;
                ena_d       = 1'b1;
                frame_err_d = done_short_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SYNC;
            cnt_q        <= '0;
            shift_q      <= '0;
            ch_q         <= LEFT;
            lr_chg_q     <= 1'b0;
            done_q       <= 1'b0;
            done_ch_q    <= LEFT;
            done_short_q <= 1'b0;
            l_hold_q     <= '0;
            have_left_q  <= 1'b0;
            l_data_q     <= '0;
            r_data_q     <= '0;
            ena_q        <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            ch_q         <= ch_d;
            lr_chg_q     <= lr_chg_d;
            done_q       <= done_d;
            done_ch_q    <= done_ch_d;
            done_short_q <= done_short_d;
            l_hold_q     <= l_hold_d;
            have_left_q  <= have_left_d;
            l_data_q     <= l_data_d;
            r_data_q     <= r_data_d;
            ena_q        <= ena_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign l_data    = l_data_q;
    assign r_data    = r_data_q;
    assign ena       = ena_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/i2s_rx.md
# i2s_rx

Stereo I2S receiver: the capture-side counterpart of the audio generator/I2S transmit path. Takes the serial bit clock, word select and data lines from an external codec ADC (or a loopback of our own I2S transmitter), oversamples them on the system clock, deserialises MSB-first words and presents a left/right pair of signed 24-bit samples with a one-cycle sample-rate strobe. Its `ena` output has the same meaning as the sample-rate enable consumed by the generator, so downstream blocks can be clocked by it directly.

## Interface
- `DW`, 24: output sample width; also the number of bits captured per channel.
- `SYNC_STAGES`, 2: synchroniser depth on `bclk`, `lrclk`, `sdin` (minimum 2).
- `clk`  in  1  system clock; the only clock; serial inputs are oversampled on it.
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge.
- `bclk`  in  1  I2S bit clock, asynchronous to `clk`.
- `lrclk`  in  1  I2S word select: 0 = left, 1 = right; asynchronous.
- `sdin`  in  1  I2S serial data, MSB first; asynchronous.
- `l_data`  out  DW  signed left sample, held between strobes.
- `r_data`  out  DW  signed right sample, held between strobes.
- `ena`  out  1  one-`clk` pulse when a new L/R pair is presented.
- `frame_err`  out  1  one-`clk` pulse when a word is terminated early.

## Operation
- Each serial input passes through `SYNC_STAGES` flops, then one extra flop for edge detection.
  - `bclk` rise = synced high and delayed low.
  - `lrclk` edge = synced value differs from the delayed value.
- All of the following happen only on a `bclk` rise. `sdin` and `lrclk` are taken from the same synchroniser stage.
- I2S framing:
  - An `lrclk` change seen at a `bclk` rise marks a word boundary.
  - The MSB is sampled at the next `bclk` rise (one-bit delay).
- FSM states:
  - SYNC: after reset. Wait for an `lrclk` 1→0 boundary (start of left) → DELAY. 0→1 boundaries are ignored.
  - DELAY: skip one `bclk` rise → SHIFT. Bit counter cleared; channel latched from `lrclk`.
  - SHIFT: shift `sdin` into the DW-bit register, MSB first, and increment the counter.
    - At counter = DW−1 (DW-th bit) the word is complete → HOLD.
  - HOLD: ignore remaining slot bits until an `lrclk` boundary → DELAY.
- Commit on word completion:
  - Left: the word goes to a left holding register.
  - Right: `l_data` ← holding register and `r_data` ← the word, together, with `ena` = 1 for one cycle.
  - Outputs never update separately.
- Short word: an `lrclk` boundary seen in SHIFT before DW bits.
  - The word is zero-filled in the LSBs (left-justified) and committed as above.
  - `frame_err` pulses in the same cycle as the commit.
  - The FSM goes to DELAY for the new channel.
- A right word with no preceding left word since SYNC is not committed. The first `ena` after reset therefore requires a full left+right pair.
- Slots longer than DW bits (e.g. 32-bit slots) are normal: the extra bits are dropped in HOLD, with no error.

## Timing
- Reset values: `l_data`=0, `r_data`=0, `ena`=0, `frame_err`=0, FSM=SYNC, synchronisers=0.
- Reset mid-frame discards any partial word and the held left word. Outputs return to 0 on the next edge.
- `bclk` high and low times must each be ≥ 3 `clk` periods (ratio `clk`/`bclk` ≥ 6). Below this, behaviour is undefined.
- Latency: a `bclk` rise at the pin → the corresponding FSM action after `SYNC_STAGES`+1 `clk` cycles. `ena` follows 1 cycle later (registered outputs).
  - DW-th right bit at the `bclk` pin → `ena` high after `SYNC_STAGES`+2 `clk` cycles; 4 cycles at the defaults.
- `ena` is never high on two consecutive cycles. At most one pulse per `lrclk` period.
- `frame_err` is coincident with the `ena` or left-commit cycle it qualifies.

## Structure
- Shared package `i2s_pkg`: FSM state encoding (SYNC, DELAY, SHIFT, HOLD), the default DW=24, the channel constants LEFT=0/RIGHT=1. The I2S transmitter also uses this package.
- One sub-module, `sync_edge`: parameterised multi-flop synchroniser with a delayed-copy output. Instantiated three times (`bclk`, `lrclk`, `sdin`).
- FSM, shift register, counter and output registers live in `i2s_rx`.

## Test plan
- Reset, then 64-bit frames (32-bit slots), `clk`/`bclk`=16, left=0x7FFFFF, right=0x800000.
  - First `ena` occurs after the first full pair, with `l_data`=0x7FFFFF and `r_data`=0x800000.
  - Exactly one `ena` per frame.
  - `frame_err` stays 0.
- Start streaming mid-right-word after reset.
  - No `ena` until a complete left then right word.
  - Partial right data never appears.
- 16-bit slots (`lrclk` toggles after 16 bits), left=0xABCD, right=0x1234.
  - `l_data`=0xABCD00, `r_data`=0x123400.
  - `frame_err` pulses once per word.
- Assert `reset` for 1 cycle midway through a right word.
  - Outputs go to 0.
  - Next `ena` only after a fresh left+right pair.
- `clk`/`bclk`=6 with random data for 1000 frames.
  - Scoreboard matches every pair.
  - `ena`-to-last-`bclk`-rise latency is exactly 4 `clk` cycles.
- Loop back the I2S transmitter driven by the audio generator, with tone bit 2 set.
  - `r_data` matches the transmitted sine samples in sequence.
  - The `l_data` ramp increments monotonically.
